// File: rtl/mask_buf_pkg.sv
// Shared types and constants for the PRNG mask buffer.
package mask_buf_pkg;

    typedef enum logic [1:0] {
        UNSEEDED = 2'd0,
        LOAD     = 2'd1,
        RUN      = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_DEPTH = 8;
    localparam int unsigned SEED_W        = 32;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mask_fifo_core.sv
// First-word-fall-through FIFO with synchronous flush and occupancy output.
module mask_fifo_core
    import mask_buf_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [clog2(DEPTH):0]    o_count
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Pops on empty and pushes on full are dropped
    assign w_do_push = i_push && (r_count != CW'(DEPTH));
    assign w_do_pop  = i_pop && (r_count != '0);
    assign o_rdata   = r_mem[r_rptr];
    assign o_count   = r_count;

    // Storage array; cleared on reset so the head reads zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers and occupancy; flush wins over any push/pop in the same cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/prng_mask_buffer.sv
// Mask buffer behind the LFSR+CASR PRNG: drives PRNG enable/load/seed, drops the
// degenerate words after each load and serves masks over valid/ready.
// Optional repetition health test: define MASK_BUF_HEALTH_EN.
module prng_mask_buffer
    import mask_buf_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned DEPTH   = DEFAULT_DEPTH,
    parameter int unsigned DISCARD = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_reseed_req,
    input  logic [SEED_W-1:0]        i_reseed_seed,
    output logic                     o_reseed_busy,
    output logic                     o_prng_enable,
    output logic                     o_prng_load,
    output logic [SEED_W-1:0]        o_prng_seed,
    input  logic [WIDTH-1:0]         i_prng_out,
    output logic                     o_mask_valid,
    input  logic                     i_mask_ready,
    output logic [WIDTH-1:0]         o_mask_data,
`ifdef MASK_BUF_HEALTH_EN
    output logic                     o_health_err,
`endif
    output logic [clog2(DEPTH):0]    o_level
);

    localparam int unsigned CW = clog2(DEPTH) + 1;

    state_e            r_state;
    state_e            w_state_d;
    logic              w_load_entry;
    logic              r_en_d;
    logic [1:0]        r_disc;
    logic [SEED_W-1:0] r_seed;
    logic              w_enable;
    logic              w_capture;
    logic              w_keep;
    logic              w_pop;
    logic              w_health_ok;
    logic [CW-1:0]     w_count;

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= UNSEEDED;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next state: requests are honoured from UNSEEDED and RUN, ignored in LOAD
    always_comb begin
        w_state_d    = r_state;
        w_load_entry = 1'b0;
        unique case (r_state)
            UNSEEDED, RUN: begin
                if (i_reseed_req) begin
                    w_state_d    = LOAD;
                    w_load_entry = 1'b1;
                end
            end
            LOAD:    w_state_d = RUN;
            default: w_state_d = UNSEEDED;
        endcase
    end

    // Enable counts the in-flight word but not same-cycle pops, so it never overfills
    assign w_enable  = (r_state == RUN) && ((32'(w_count) + 32'(r_en_d)) < DEPTH);
    assign w_capture = (r_state == RUN) && r_en_d;
    assign w_keep    = w_capture && (r_disc == 2'd0);

    assign o_prng_enable = w_enable;
    assign o_prng_load   = (r_state == LOAD);
    assign o_reseed_busy = (r_state != RUN);
    assign o_prng_seed   = r_seed;
    assign o_mask_valid  = (w_count != '0) && (r_state == RUN) && w_health_ok;
    assign o_level       = w_count;
    assign w_pop         = o_mask_valid && i_mask_ready;

    // Seed, capture pipeline and discard counter; a load drops any in-flight word
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seed <= '0;
            r_en_d <= 1'b0;
            r_disc <= '0;
        end else if (w_load_entry) begin
            r_seed <= i_reseed_seed;
            r_en_d <= 1'b0;
            r_disc <= 2'(DISCARD);
        end else begin
            r_en_d <= w_enable;
            if (w_capture && (r_disc != 2'd0)) begin
                r_disc <= r_disc - 2'd1;
            end
        end
    end

`ifdef MASK_BUF_HEALTH_EN
    logic [WIDTH-1:0] r_prev;
    logic             r_prev_vld;
    logic             r_health;

    // Repetition test on consecutive kept words; sticky until the next load
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
            r_health   <= 1'b0;
        end else if (w_load_entry) begin
            r_prev_vld <= 1'b0;
            r_health   <= 1'b0;
        end else if (w_keep) begin
            if (r_prev_vld && (i_prng_out == r_prev)) begin
                r_health <= 1'b1;
            end
            r_prev     <= i_prng_out;
            r_prev_vld <= 1'b1;
        end
    end

    assign w_health_ok  = !r_health;
    assign o_health_err = r_health;
`else
    assign w_health_ok = 1'b1;
`endif

    mask_fifo_core #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (w_load_entry),
        .i_push  (w_keep),
        .i_wdata (i_prng_out),
        .i_pop   (w_pop),
        .o_rdata (o_mask_data),
        .o_count (w_count)
    );

endmodule

// File: tb/tb_prng_mask_buffer.sv
// Bench for prng_mask_buffer with a stub PRNG and an occupancy/sequence reference.
module tb_prng_mask_buffer;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned DISCARD = 1;
    localparam int unsigned LW      = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             reseed_req;
    logic [31:0]      reseed_seed;
    logic             reseed_busy;
    logic             prng_enable;
    logic             prng_load;
    logic [31:0]      prng_seed;
    logic [WIDTH-1:0] prng_out;
    logic             mask_valid;
    logic             mask_ready;
    logic [WIDTH-1:0] mask_data;
    logic [LW-1:0]    level;
`ifdef MASK_BUF_HEALTH_EN
    logic             health_err;
`endif

    always #5 clk = ~clk;

    prng_mask_buffer #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .DISCARD (DISCARD)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_reseed_req  (reseed_req),
        .i_reseed_seed (reseed_seed),
        .o_reseed_busy (reseed_busy),
        .o_prng_enable (prng_enable),
        .o_prng_load   (prng_load),
        .o_prng_seed   (prng_seed),
        .i_prng_out    (prng_out),
        .o_mask_valid  (mask_valid),
        .i_mask_ready  (mask_ready),
        .o_mask_data   (mask_data),
`ifdef MASK_BUF_HEALTH_EN
        .o_health_err  (health_err),
`endif
        .o_level       (level)
    );

    // Stub PRNG word k after a load: 0, 0x11, 0x22, ...; rep makes word 3 repeat 0x22
    bit rep;
    int unsigned stub_k;

    function automatic logic [31:0] stub_word(input int unsigned k);
        if (rep && (k == 3)) return 32'h22;
        return 32'h11 * k;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prng_out <= '0;
            stub_k   <= 0;
        end else if (prng_load) begin
            stub_k <= 0;
        end else if (prng_enable) begin
            prng_out <= stub_word(stub_k);
            stub_k   <= stub_k + 1;
        end
    end

    int          n_assert;
    int          n_fail;
    int          m_state;   // 0 unseeded, 1 load, 2 run
    int          kept;
    int          pops;
    int          disc_left;
    bit          prev_en;
    bit          h_exp;
    logic [31:0] m_seed;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state   = 0;
        kept      = 0;
        pops      = 0;
        disc_left = 0;
        prev_en   = 1'b0;
        h_exp     = 1'b0;
        m_seed    = '0;
    endtask

    // Check the current cycle against the reference, account for the edge, advance
    task automatic tick();
        int lvl;
        bit exp_valid;
        bit exp_en;
        lvl       = kept - pops;
        exp_valid = (m_state == 2) && (lvl != 0) && !h_exp;
        exp_en    = (m_state == 2) && ((lvl + int'(prev_en)) < int'(DEPTH));
        chk("busy", reseed_busy, m_state != 2);
        chk("load", prng_load, m_state == 1);
        chk("seed", prng_seed, m_seed);
        chk("level", level, lvl);
        chk("enable", prng_enable, exp_en);
        chk("valid", mask_valid, exp_valid);
`ifdef MASK_BUF_HEALTH_EN
        chk("health", health_err, h_exp);
`endif
        if (exp_valid && mask_ready) begin
            chk("data", mask_data, stub_word(pops + DISCARD));
            pops++;
        end
        if ((m_state == 2) && prev_en) begin
            if (disc_left > 0) begin
                disc_left--;
            end else begin
                if ((kept > 0) &&
                    (stub_word(kept + DISCARD) == stub_word(kept + DISCARD - 1))) begin
                    h_exp = 1'b1;
                end
                kept++;
            end
        end
        prev_en = prng_enable;
        if ((m_state != 1) && reseed_req) begin
            kept      = 0;
            pops      = 0;
            disc_left = DISCARD;
            h_exp     = 1'b0;
            m_seed    = reseed_seed;
            m_state   = 1;
        end else if (m_state == 1) begin
            m_state = 2;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit found;
        n_assert    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        reseed_req  = 1'b0;
        reseed_seed = '0;
        mask_ready  = 1'b0;
        rep         = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", reseed_busy, 1);
        chk("rst_enable", prng_enable, 0);
        chk("rst_load", prng_load, 0);
        chk("rst_seed", prng_seed, 0);
        chk("rst_valid", mask_valid, 0);
        chk("rst_data", mask_data, 0);
        chk("rst_level", level, 0);
        rst_n = 1'b1;
        repeat (10) tick();

        // First seed; the request is held into LOAD with another seed, which must be ignored
        reseed_seed = 32'hDEADBEEF;
        reseed_req  = 1'b1;
        chk("c0_load", prng_load, 0);
        tick();
        reseed_seed = 32'h0BADF00D;
        chk("c1_load", prng_load, 1);
        chk("c1_seed", prng_seed, 32'hDEADBEEF);
        chk("c1_enable", prng_enable, 0);
        tick();
        reseed_req = 1'b0;
        chk("c2_enable", prng_enable, 1);
        chk("c2_seed", prng_seed, 32'hDEADBEEF);
        tick();
        tick();
        chk("c4_valid", mask_valid, 0);
        tick();
        chk("c5_valid", mask_valid, 1);
        chk("c5_data", mask_data, 32'h11);

        // Fill to saturation
        repeat (12) tick();
        chk("full_level", level, DEPTH);
        chk("full_enable", prng_enable, 0);

        // Pop at full, then pop again in the cycle the refill word lands
        mask_ready = 1'b1;
        tick();
        mask_ready = 1'b0;
        tick();
        mask_ready = 1'b1;
        tick();
        mask_ready = 1'b0;
        chk("pop_push_level", level, 7);

        // Continuous draining must never starve
        mask_ready = 1'b1;
        repeat (30) begin
            chk("stream_valid", mask_valid, 1);
            tick();
        end

        // Random ready with occasional reseeds
        repeat (400) begin
            mask_ready  = ($urandom_range(0, 2) != 0);
            reseed_req  = ($urandom_range(0, 63) == 0);
            reseed_seed = $urandom;
            tick();
        end
        reseed_req = 1'b0;

        // Reseed while five words are held and one capture is in flight
        mask_ready  = 1'b0;
        reseed_req  = 1'b1;
        reseed_seed = 32'hCAFE0001;
        tick();
        reseed_req = 1'b0;
        found      = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (level == LW'(5)) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("wait_level5", found, 1);
        chk("inflight_en", prev_en, 1);
        reseed_req  = 1'b1;
        reseed_seed = 32'hCAFE0002;
        tick();
        reseed_req = 1'b0;
        chk("flush_level", level, 0);
        chk("flush_seed", prng_seed, 32'hCAFE0002);
        mask_ready = 1'b1;
        found      = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (mask_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("wait_post_load", found, 1);
        chk("post_load_data", mask_data, 32'h11);
        repeat (10) tick();

`ifdef MASK_BUF_HEALTH_EN
        // Repeated 0x22 trips the health flag until the next load
        mask_ready  = 1'b0;
        rep         = 1'b1;
        reseed_req  = 1'b1;
        reseed_seed = 32'h12345678;
        tick();
        reseed_req = 1'b0;
        repeat (10) tick();
        chk("health_set", health_err, 1);
        chk("health_valid", mask_valid, 0);
        rep         = 1'b0;
        reseed_req  = 1'b1;
        reseed_seed = 32'h87654321;
        tick();
        reseed_req = 1'b0;
        chk("health_clr", health_err, 0);
        mask_ready = 1'b1;
        found      = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (mask_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("health_wait_valid", found, 1);
        chk("health_data", mask_data, 32'h11);
        repeat (10) tick();
`endif

        // Asynchronous reset in the middle of a cycle
        mask_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", reseed_busy, 1);
        chk("arst_enable", prng_enable, 0);
        chk("arst_valid", mask_valid, 0);
        chk("arst_seed", prng_seed, 0);
        chk("arst_level", level, 0);
        chk("arst_data", mask_data, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
